mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameters, one per line:
- RAM_AW, default 17, RAM byte-address width (128 KB).
- TX_LOG2, default 3, log2 of TX FIFO depth.
- RX_LOG2, default 2, log2 of RX FIFO depth.
REQ-002 SHALL have ports, one per line:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- mem_a  in  32  CPU byte address.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  in  8  CPU write data.
- mem_din  out  8  read data to CPU.
- io_buffer_full  out  1  TX FIFO nearly full.
- cpu_rdy  out  1  CPU run enable.
- halted  out  1  program-stop flag.
- tx_data  out  8  UART TX byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- rx_data  in  8  UART RX byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO can accept.
- tx_overflow  out  1  sticky TX drop flag.
REQ-003 SHALL use one clock (clk_in) and asynchronous active-low reset (rst_in).

Function
REQ-004 SHALL decode mem_a[17:16]==2'b11 as I/O space; otherwise RAM at index mem_a[RAM_AW-1:0].
REQ-005 SHALL service one access per cycle; each cycle with mem_wr=0 is a read.
REQ-006 SHALL commit a RAM write at the edge it is sampled; no wait states.
REQ-007 SHALL register read data: mem_din valid the cycle after the address is sampled, held until the next read.
REQ-008 SHALL handle a write to 0x30000: push mem_dout into the TX FIFO when nonzero; 0x00 is ignored.
REQ-009 SHALL handle a TX push while the FIFO is full: drop the byte and set tx_overflow, which stays set until reset.
REQ-010 SHALL handle a write to 0x30004: push 0x00 into the TX FIFO (bypasses the zero filter) and set halted the next cycle.
REQ-011 SHALL handle a read of 0x30000: return the RX FIFO head and pop it; return 0x00 with no pop if the FIFO is empty.
REQ-012 SHALL handle a read of 0x30004+k (k = mem_a[1:0]): return byte k of the 32-bit cycle counter sampled that cycle.
REQ-013 SHALL, for other I/O addresses, read 0x00 and ignore writes.
REQ-014 SHALL increment the cycle counter every cycle while halted=0, freeze it when halted=1, and wrap 0xFFFFFFFF to 0.
REQ-015 SHALL drive tx_valid = TX FIFO not empty and tx_data = head; pop on tx_valid && tx_ready.
REQ-016 SHALL keep the TX count unchanged on a simultaneous TX push and pop, including when the FIFO is full.
REQ-017 SHALL drive io_buffer_full high when TX count >= 2^TX_LOG2 - 1; it is combinational from the count.
REQ-018 SHALL drive rx_ready = RX FIFO not full and push on rx_valid && rx_ready.
REQ-019 SHALL handle a simultaneous RX push and pop: count unchanged, FIFO order preserved.
REQ-020 SHALL drive cpu_rdy low while halted=1; cpu_rdy returns high only via reset.
REQ-021 SHALL ignore mem_wr writes while halted=1; reads still complete.

Reset
REQ-022 SHALL, while rst_in=0, force mem_din=0, tx_valid=0, io_buffer_full=0, halted=0, cpu_rdy=0, tx_overflow=0, counter=0 and both FIFOs empty.
REQ-023 SHALL raise cpu_rdy at the first clk_in rising edge after rst_in deasserts.
REQ-024 SHALL NOT reset RAM contents.
REQ-025 SHALL, on reset asserted mid-operation, immediately discard in-flight TX/RX bytes and any pending read data.

Verification
REQ-026 SHALL cover: write 0xA5 @0x00010, read @0x00010 next cycle -> mem_din=0xA5 one cycle later.
REQ-027 SHALL cover: 7 writes of 0x41 @0x30000 with tx_ready=0 (depth 8) -> io_buffer_full=1 after the 7th; 8th accepted; 9th dropped with tx_overflow=1.
REQ-028 SHALL cover: write 0x00 @0x30000 -> no push; write any value @0x30004 -> tx_data=0x00 queued, halted=1, cpu_rdy=0, counter frozen.
REQ-029 SHALL cover: rx bytes 0x31, 0x32 pushed, three reads @0x30000 -> 0x31, 0x32, 0x00.
REQ-030 SHALL cover: reads @0x30004..0x30007 after 300 cycles -> bytes LSB-first of the counter (0x2C/0x01 region), consistent with the sampling cycle.
REQ-031 SHALL cover: rst_in pulsed low mid-TX-drain -> tx_valid=0 immediately, counter=0, cpu_rdy high one edge after release.

Source files
------------

// File: rtl/mem_io_responder.sv
// CPU memory/I-O responder: byte RAM, UART TX/RX FIFOs, a free-running cycle
// counter and a halt flag, all serviced one access per clock with registered reads.
module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int TX_LOG2 = 3,
  parameter int RX_LOG2 = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        cpu_rdy,
  output logic        halted,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow
);

  localparam int TX_DEPTH = 1 << TX_LOG2;
  localparam int RX_DEPTH = 1 << RX_LOG2;
  localparam logic [TX_LOG2:0] TX_FULL = (TX_LOG2 + 1)'(TX_DEPTH);
  localparam logic [TX_LOG2:0] TX_NEAR = (TX_LOG2 + 1)'(TX_DEPTH - 1);
  localparam logic [RX_LOG2:0] RX_FULL = (RX_LOG2 + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALT} run_state_t;

  run_state_t state, state_next;

  logic [7:0] ram [0:(1 << RAM_AW) - 1];
  logic [7:0] ram_q;
  logic [7:0] io_q, io_rdata;
  logic       rd_from_ram;
  logic [31:0] cycle_cnt;

  logic [7:0]         tx_mem [0:TX_DEPTH - 1];
  logic [TX_LOG2-1:0] tx_wp, tx_rp;
  logic [TX_LOG2:0]   tx_count;
  logic [7:0]         rx_mem [0:RX_DEPTH - 1];
  logic [RX_LOG2-1:0] rx_wp, rx_rp;
  logic [RX_LOG2:0]   rx_count;

  logic              io_sel, tx_sel, halt_sel, cnt_sel;
  logic              wr_en, rd_en, ram_we, halt_wr;
  logic              tx_push, tx_pop, tx_accept, rx_push, rx_pop;
  logic [7:0]        tx_push_data;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr;

  // Upper address bits take no part in the decode.
  assign unused_addr = ^mem_a[31:18];

  assign io_sel   = (mem_a[17:16] == 2'b11);
  assign tx_sel   = io_sel && (mem_a[15:0] == 16'h0000);
  assign halt_sel = io_sel && (mem_a[15:0] == 16'h0004);
  assign cnt_sel  = io_sel && (mem_a[15:2] == 14'h0001);
  assign ram_idx  = mem_a[RAM_AW-1:0];

  assign wr_en   = mem_wr && (state != ST_HALT);
  assign rd_en   = !mem_wr;
  assign ram_we  = wr_en && !io_sel;
  assign halt_wr = wr_en && halt_sel;

  // The halt write queues a 0x00 terminator, the only way a zero reaches the UART.
  assign tx_push      = (wr_en && tx_sel && (mem_dout != 8'h00)) || halt_wr;
  assign tx_push_data = halt_wr ? 8'h00 : mem_dout;
  assign tx_valid     = (tx_count != '0);
  assign tx_data      = tx_mem[tx_rp];
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_accept    = tx_push && ((tx_count != TX_FULL) || tx_pop);
  assign io_buffer_full = (tx_count >= TX_NEAR);

  assign rx_ready = (rx_count != RX_FULL);
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_en && tx_sel && (rx_count != '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_START;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    halted     = 1'b0;
    cpu_rdy    = 1'b0;
    case (state)
      ST_START: state_next = halt_wr ? ST_HALT : ST_RUN;
      ST_RUN: begin
        cpu_rdy = 1'b1;
        if (halt_wr) state_next = ST_HALT;
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_START;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                cycle_cnt <= 32'd0;
    else if (state != ST_HALT)  cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Storage arrays carry no reset so they can map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (ram_we)              ram[ram_idx] <= mem_dout;
    if (rd_en && !io_sel)    ram_q <= ram[ram_idx];
    if (tx_accept)           tx_mem[tx_wp] <= tx_push_data;
    if (rx_push)             rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_accept) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)    tx_rp <= tx_rp + 1'b1;
      if (tx_accept && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_accept && tx_pop) tx_count <= tx_count - 1'b1;
      if (tx_push && !tx_accept) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    if (tx_sel && (rx_count != '0)) begin
      io_rdata = rx_mem[rx_rp];
    end else if (cnt_sel) begin
      case (mem_a[1:0])
        2'd0:    io_rdata = cycle_cnt[7:0];
        2'd1:    io_rdata = cycle_cnt[15:8];
        2'd2:    io_rdata = cycle_cnt[23:16];
        default: io_rdata = cycle_cnt[31:24];
      endcase
    end
  end

  // Read source is remembered so mem_din holds across write cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_from_ram <= 1'b0;
      io_q        <= 8'h00;
    end else if (rd_en) begin
      rd_from_ram <= !io_sel;
      io_q        <= io_rdata;
    end
  end

  assign mem_din = rd_from_ram ? ram_q : io_q;

endmodule
